// File: rtl/reg_bank_cmd_ctrl.sv
// Byte-command front end for the register bank: decodes 1-byte reads and
// 2-byte writes from the UART receiver, drives the bank, and returns read data.
module reg_bank_cmd_ctrl #(
  parameter int unsigned ADDR_BITS      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1200000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  input  logic                 tx_busy,
  output logic [7:0]           tx_data,
  output logic                 tx_start,
  output logic [ADDR_BITS-1:0] bank_addr,
  output logic [7:0]           bank_data_w,
  output logic                 bank_wd,
  input  logic [7:0]           bank_data_r,
  output logic                 err
);

  localparam int unsigned          CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GET_DATA,
    S_WRITE,
    S_READ,
    S_SEND,
    S_HOLD
  } state_t;

  state_t               r_state,    w_state_nx;
  logic [CNT_W-1:0]     r_cnt,      w_cnt_nx;
  logic [7:0]           r_tx_data,  w_tx_data_nx;
  logic                 r_tx_start, w_tx_start_nx;
  logic [ADDR_BITS-1:0] r_addr,     w_addr_nx;
  logic [7:0]           r_data_w,   w_data_w_nx;
  logic                 r_wd,       w_wd_nx;
  logic                 r_err,      w_err_nx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_tx_data  <= '0;
      r_tx_start <= 1'b0;
      r_addr     <= '0;
      r_data_w   <= '0;
      r_wd       <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_cnt      <= w_cnt_nx;
      r_tx_data  <= w_tx_data_nx;
      r_tx_start <= w_tx_start_nx;
      r_addr     <= w_addr_nx;
      r_data_w   <= w_data_w_nx;
      r_wd       <= w_wd_nx;
      r_err      <= w_err_nx;
    end
  end

  // Every output is computed one cycle ahead so the registered version lines
  // up with the state it belongs to (e.g. bank_wd high exactly in WRITE).
  always_comb begin
    w_state_nx    = r_state;
    w_cnt_nx      = r_cnt;
    w_tx_data_nx  = r_tx_data;
    w_tx_start_nx = 1'b0;
    w_addr_nx     = r_addr;
    w_data_w_nx   = r_data_w;
    w_wd_nx       = 1'b0;
    w_err_nx      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (rx_valid) begin
          w_addr_nx = rx_data[ADDR_BITS-1:0];
          if (rx_data[7]) begin
            w_state_nx = S_GET_DATA;
            w_cnt_nx   = '0;
          end else begin
            w_state_nx = S_READ;
          end
        end
      end
      S_GET_DATA: begin
        if (rx_valid) begin
          w_data_w_nx = rx_data;
          w_wd_nx     = 1'b1;
          w_state_nx  = S_WRITE;
        end else if (r_cnt == CNT_LAST) begin
          w_err_nx   = 1'b1;
          w_state_nx = S_IDLE;
        end else begin
          w_cnt_nx = r_cnt + CNT_W'(1);
        end
      end
      S_WRITE: begin
        w_err_nx   = rx_valid;
        w_state_nx = S_IDLE;
      end
      S_READ: begin
        w_err_nx     = rx_valid;
        w_tx_data_nx = bank_data_r;
        w_state_nx   = S_SEND;
      end
      S_SEND: begin
        w_err_nx = rx_valid;
        if (!tx_busy) begin
          w_tx_start_nx = 1'b1;
          w_state_nx    = S_HOLD;
        end
      end
      S_HOLD: begin
        w_err_nx   = rx_valid;
        w_state_nx = S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  assign tx_data     = r_tx_data;
  assign tx_start    = r_tx_start;
  assign bank_addr   = r_addr;
  assign bank_data_w = r_data_w;
  assign bank_wd     = r_wd;
  assign err         = r_err;

endmodule

// File: tb/tb_reg_bank_cmd_ctrl.sv
// Self-checking bench for reg_bank_cmd_ctrl: directed and randomized command
// transactions checked against a transaction-level bank model and timing rules.
module tb_reg_bank_cmd_ctrl;

  localparam int unsigned T = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_busy;
  logic [7:0] tx_data;
  logic       tx_start;
  logic [3:0] bank_addr;
  logic [7:0] bank_data_w;
  logic       bank_wd;
  logic [7:0] bank_data_r;
  logic       err;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] bank    [16] = '{default: 8'h00};
  logic [7:0] ref_mem [16] = '{default: 8'h00};

  reg_bank_cmd_ctrl #(
    .ADDR_BITS      (4),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .tx_busy     (tx_busy),
    .tx_data     (tx_data),
    .tx_start    (tx_start),
    .bank_addr   (bank_addr),
    .bank_data_w (bank_data_w),
    .bank_wd     (bank_wd),
    .bank_data_r (bank_data_r),
    .err         (err)
  );

  always #5 clk = ~clk;

  // Simple register bank attached to the DUT write/read ports
  assign bank_data_r = bank[bank_addr];
  always @(posedge clk) if (bank_wd) bank[bank_addr] <= bank_data_w;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_cycle(input string tag, input logic exp_wd, input logic exp_start,
                           input logic exp_err);
    chk({tag, "_wd"},    bank_wd,  exp_wd);
    chk({tag, "_start"}, tx_start, exp_start);
    chk({tag, "_err"},   err,      exp_err);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_tx_data"}, tx_data,     0);
    chk({tag, "_start"},   tx_start,    0);
    chk({tag, "_addr"},    bank_addr,   0);
    chk({tag, "_data_w"},  bank_data_w, 0);
    chk({tag, "_wd"},      bank_wd,     0);
    chk({tag, "_err"},     err,         0);
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    rx_valid = 1'b0;
    tx_busy  = 1'b0;
    #2 rst = 1'b1;
    #1 chk_reset("rst_async");
    tick();
    chk_reset("rst_hold");
    rst = 1'b0;
  endtask

  // Write: cmd byte, 'gap' silent cycles (< T), data byte. bank_wd is seen in
  // the cycle after the data byte. Optional extra byte during WRITE is dropped.
  task automatic do_write(input logic [7:0] cmd, input logic [7:0] d,
                          input int unsigned gap, input bit drop);
    logic [3:0] a;
    a = cmd[3:0];
    send_byte(cmd | 8'h80);
    for (int unsigned c = 0; c < gap; c++) begin
      chk_cycle("wr_wait", 0, 0, 0);
      tick();
    end
    chk_cycle("wr_wait", 0, 0, 0);
    send_byte(d);
    chk_cycle("wr_commit", 1, 0, 0);
    chk("wr_addr", bank_addr, a);
    chk("wr_data", bank_data_w, d);
    if (drop) begin
      rx_data  = 8'($urandom);
      rx_valid = 1'b1;
    end
    tick();
    rx_valid = 1'b0;
    chk_cycle("wr_after", 0, 0, drop);
    chk("wr_addr_hold", bank_addr, a);
    chk("wr_data_hold", bank_data_w, d);
    ref_mem[a] = d;
  endtask

  // Read: tx_busy high until SEND has seen 'busy' busy cycles, so tx_start
  // lands at cycle 3+busy after the cmd byte. drop_at (1..3+busy) injects a
  // stray byte that must only produce err one cycle later.
  task automatic do_read(input logic [7:0] cmd, input int unsigned busy,
                         input int unsigned drop_at);
    logic [3:0]  a;
    int unsigned ts;
    a  = cmd[3:0];
    ts = 3 + busy;
    tx_busy = (busy > 0);
    send_byte(cmd & 8'h7F);
    for (int unsigned c = 1; c <= ts + 1; c++) begin
      chk_cycle("rd", 0, (c == ts), (drop_at != 0 && c == drop_at + 1));
      if (c == 1) chk("rd_addr", bank_addr, a);
      if (c >= ts) chk("rd_data", tx_data, ref_mem[a]);
      tx_busy = (c < 2 + busy);
      if (c == drop_at) begin
        rx_data  = 8'h80 | 8'($urandom);
        rx_valid = 1'b1;
      end else begin
        rx_valid = 1'b0;
      end
      tick();
    end
    rx_valid = 1'b0;
    tx_busy  = 1'b0;
    chk_cycle("rd_done", 0, 0, 0);
  endtask

  // Write command with no data byte: err T+1 cycles after the cmd byte.
  task automatic do_timeout(input logic [7:0] cmd);
    send_byte(cmd | 8'h80);
    for (int unsigned c = 1; c <= T; c++) begin
      chk_cycle("to_wait", 0, 0, 0);
      tick();
    end
    chk_cycle("to_err", 0, 0, 1);
    chk("to_addr", bank_addr, cmd[3:0]);
    tick();
    chk_cycle("to_after", 0, 0, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

  initial begin
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    tx_busy  = 1'b0;
    tick();
    chk_reset("reset");
    rst = 1'b0;
    tick();

    do_write(8'h83, 8'h5A, 0, 0);
    do_read(8'h03, 0, 0);

    do_write(8'h85, 8'hC3, 2, 0);
    do_timeout(8'h85);
    do_read(8'h05, 0, 0);

    do_read(8'h03, 50, 0);
    do_read(8'h03, 4, 3);
    do_write(8'h8A, 8'h99, T - 1, 0);
    do_read(8'h7A, 1, 1);
    do_write(8'hF1, 8'h17, 1, 1);
    do_read(8'h01, 2, 5);

    send_byte(8'h87);
    tick();
    tick();
    pulse_reset();
    do_write(8'h82, 8'h6E, 0, 0);
    send_byte(8'h87);
    tick();
    pulse_reset();
    do_read(8'h22, 0, 0);
    chk("partial_write_ignored", bank[7], ref_mem[7]);

    tx_busy = 1'b1;
    send_byte(8'h02);
    tick();
    tick();
    tick();
    pulse_reset();
    for (int unsigned c = 0; c < 6; c++) begin
      chk_cycle("rst_in_send", 0, 0, 0);
      tick();
    end

    for (int unsigned i = 0; i < 60; i++) begin
      int unsigned op;
      int unsigned busy;
      op = $urandom_range(0, 9);
      if (op < 4) begin
        do_write(8'($urandom), 8'($urandom), $urandom_range(0, T - 1),
                 ($urandom_range(0, 3) == 0));
      end else if (op < 9) begin
        busy = $urandom_range(0, 5);
        do_read(8'($urandom), busy,
                ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3 + busy) : 0);
      end else begin
        do_timeout(8'($urandom));
      end
      for (int unsigned k = $urandom_range(0, 2); k > 0; k--) tick();
    end

    for (int unsigned a = 0; a < 16; a++) begin
      chk("bank_final", bank[a], ref_mem[a]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
